// File: rtl/crc_code_decoder_pkg.sv
// ----------------------------------------------------------------------------
// crc_code_decoder_pkg
//
// Purpose : Shared constants and types for the CRC-4 codeword checker and any
//           matching encoder. Holds the generator polynomial, the field
//           widths of a codeword, the checker FSM state type and a small
//           saturating-increment helper for the error counter.
//
// Contents:
//   CRC_POLY   - generator x^4 + x + 1, x^4 term implicit (4'b0011)
//   DATA_W     - data bits per codeword (8)
//   CHK_W      - check bits per codeword (4)
//   ADDR_W     - width of the address tag travelling with a codeword (4)
//   CODE_W     - full codeword width, data above check bits (12)
//   CNT_W      - width of the shift counter that walks the data bits (3)
//   ERRCNT_W   - width of the saturating error counter (8)
//   state_e    - IDLE / SHIFT / CHECK
//   satInc()   - increment that sticks at all-ones
// ----------------------------------------------------------------------------
package crc_code_decoder_pkg;

    localparam logic [3:0] CRC_POLY = 4'b0011;

    localparam int DATA_W   = 8;
    localparam int CHK_W    = 4;
    localparam int ADDR_W   = 4;
    localparam int CODE_W   = DATA_W + CHK_W;
    localparam int CNT_W    = 3;
    localparam int ERRCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    // Counter increment that stops at the top value instead of wrapping,
    // so a long burst of bad words never makes the count look small again.
    function automatic logic [ERRCNT_W-1:0] satInc(input logic [ERRCNT_W-1:0] value);
        logic [ERRCNT_W-1:0] result;
        if (value == {ERRCNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_code_decoder_lfsr.sv
// ----------------------------------------------------------------------------
// crc4_lfsr_step
//
// Purpose : One combinational step of the serial CRC-4 remainder register.
//           The register holds the running remainder of the data polynomial
//           divided by x^4 + x + 1. Each step shifts the remainder up by one
//           position, brings the next data bit (MSB first) in at bit 0, and
//           folds the generator back in when the old top bit falls off.
//           Kept as its own module so an encoder can reuse the exact same
//           step.
//
// Ports   :
//   state_i [3:0] - current remainder
//   bit_i         - next data bit, most significant first
//   next_o  [3:0] - remainder after absorbing bit_i
// ----------------------------------------------------------------------------
module crc4_lfsr_step
    import crc_code_decoder_pkg::*;
(
    input  logic [CHK_W-1:0] state_i,
    input  logic             bit_i,
    output logic [CHK_W-1:0] next_o
);

    // Shift-and-reduce: {old[2:0], in} XOR (old[3] ? poly : 0). With the
    // polynomial 4'b0011 this expands to
    //   next[3] = old[2], next[2] = old[1],
    //   next[1] = old[3] ^ old[0], next[0] = old[3] ^ in.
    always_comb begin
        next_o = {state_i[CHK_W-2:0], bit_i} ^ (state_i[CHK_W-1] ? CRC_POLY : '0);
    end

endmodule

// File: rtl/crc_code_decoder.sv
// ----------------------------------------------------------------------------
// crc_code_decoder
//
// Purpose : Checks a 12-bit codeword (8 data bits over 4 CRC-4 check bits)
//           against the generator x^4 + x + 1. The data bits are run through
//           a serial remainder register, one bit per clock, and the result is
//           compared with the received check bits. Detection only: the data
//           is passed through unchanged, never corrected. One codeword is
//           processed every 10 cycles, and a new start is accepted in the same
//           cycle the previous result is flagged valid.
//
// Ports   :
//   clk            - rising-edge clock
//   rst            - synchronous, active-high reset
//   code_in  [11:0]- received codeword, [11:4] data, [3:0] check bits
//   addr_in  [3:0] - address tag captured alongside the codeword
//   start          - begin a check; only looked at while ready is high
//   ready          - high only when idle and able to take a start
//   valid          - one-cycle pulse when new results appear
//   data_out [7:0] - captured data bits of the last checked word
//   addr_out [3:0] - captured address tag of the last checked word
//   syndrome [3:0] - recomputed check XOR received check bits
//   error          - syndrome is non-zero
//   err_cnt  [7:0] - saturating count of words that failed the check
//
// Timing  : start sampled at edge E0 -> eight remainder steps at E1..E8 ->
//           results registered at E9 -> valid high during the cycle after E9.
// ----------------------------------------------------------------------------
module crc_code_decoder
    import crc_code_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   code_in,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic                start,
    output logic                ready,
    output logic                valid,
    output logic [DATA_W-1:0]   data_out,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [CHK_W-1:0]    syndrome,
    output logic                error,
    output logic [ERRCNT_W-1:0] err_cnt
);

    // Control and working registers.
    state_e              state_q,   state_d;
    logic [CHK_W-1:0]    lfsr_q,    lfsr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [CODE_W-1:0]   code_q,    code_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;

    // Result registers, held between valid pulses.
    logic [DATA_W-1:0]   dataOut_q, dataOut_d;
    logic [ADDR_W-1:0]   addrOut_q, addrOut_d;
    logic [CHK_W-1:0]    syn_q,     syn_d;
    logic                err_q,     err_d;
    logic [ERRCNT_W-1:0] errCnt_q,  errCnt_d;
    logic                valid_q,   valid_d;

    // Combinational helpers.
    logic [DATA_W-1:0]   capturedData;
    logic [CHK_W-1:0]    capturedCheck;
    logic [CNT_W-1:0]    bitIdx;
    logic                shiftBit;
    logic [CHK_W-1:0]    lfsrStep;
    logic [CHK_W-1:0]    checkSyn;

    // Split the held codeword into its data and check fields, and pick the
    // data bit for this step. The counter runs 0..7, so data bit 7 (the x^7
    // coefficient) goes in first and bit 0 last. The captured codeword is
    // never shifted, so it stays exactly as received for the whole check.
    always_comb begin
        capturedData  = code_q[CODE_W-1:CHK_W];
        capturedCheck = code_q[CHK_W-1:0];
        bitIdx        = CNT_W'(DATA_W - 1) - cnt_q;
        shiftBit      = capturedData[bitIdx];
        checkSyn      = lfsr_q ^ capturedCheck;
    end

    crc4_lfsr_step uStep (
        .state_i (lfsr_q),
        .bit_i   (shiftBit),
        .next_o  (lfsrStep)
    );

    // State register and all datapath registers. Reset wins over everything,
    // so a reset mid-check drops the word without a valid pulse and without
    // touching the error count beyond clearing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            addr_q    <= '0;
            dataOut_q <= '0;
            addrOut_q <= '0;
            syn_q     <= '0;
            err_q     <= 1'b0;
            errCnt_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            dataOut_q <= dataOut_d;
            addrOut_q <= addrOut_d;
            syn_q     <= syn_d;
            err_q     <= err_d;
            errCnt_q  <= errCnt_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state and datapath update. Everything holds by default and valid
    // defaults low, so it is only ever a single-cycle pulse following CHECK.
    // IDLE captures a new word on start; SHIFT absorbs one data bit per cycle
    // and leaves after the eighth; CHECK publishes the results and returns to
    // IDLE, which is what lets the next start land in the valid cycle.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        addr_d    = addr_q;
        dataOut_d = dataOut_q;
        addrOut_d = addrOut_q;
        syn_d     = syn_q;
        err_d     = err_q;
        errCnt_d  = errCnt_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d  = code_in;
                    addr_d  = addr_in;
                    lfsr_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                lfsr_d = lfsrStep;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                syn_d     = checkSyn;
                err_d     = |checkSyn;
                dataOut_d = capturedData;
                addrOut_d = addr_q;
                valid_d   = 1'b1;
                if (|checkSyn) begin
                    errCnt_d = satInc(errCnt_q);
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drive the ports straight from registers; ready follows the state.
    always_comb begin
        ready    = (state_q == IDLE);
        valid    = valid_q;
        data_out = dataOut_q;
        addr_out = addrOut_q;
        syndrome = syn_q;
        error    = err_q;
        err_cnt  = errCnt_q;
    end

endmodule

// File: tb/tb_crc_code_decoder.sv
// ----------------------------------------------------------------------------
// tb_crc_code_decoder
//
// Purpose : Self-checking bench for crc_code_decoder. Expected results are
//           computed from a polynomial long-division reference and pushed to
//           a scoreboard queue when a start is accepted; a monitor pops and
//           compares on every valid pulse, including the start-to-valid
//           latency. Directed steps cover clean words, data- and check-bit
//           errors, ignored starts while busy, back-to-back starts, counter
//           saturation and an aborting reset.
// ----------------------------------------------------------------------------
module tb_crc_code_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] code_in;
    logic [3:0]  addr_in;
    logic        start;
    logic        ready;
    logic        valid;
    logic [7:0]  data_out;
    logic [3:0]  addr_out;
    logic [3:0]  syndrome;
    logic        error;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [7:0] data;
        logic [3:0] addr;
        logic [3:0] syn;
        logic       err;
        logic [7:0] cnt;
        int         startCyc;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   modelCnt   = 0;

    crc_code_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .code_in  (code_in),
        .addr_in  (addr_in),
        .start    (start),
        .ready    (ready),
        .valid    (valid),
        .data_out (data_out),
        .addr_out (addr_out),
        .syndrome (syndrome),
        .error    (error),
        .err_cnt  (err_cnt)
    );

    // 10 ns clock; the cycle count lets the monitor measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference remainder: long division of D(x) by x^4 + x + 1 (0x13).
    function automatic logic [3:0] refCrc(input logic [7:0] d);
        logic [11:0] r;
        r = {4'b0000, d};
        for (int i = 7; i >= 4; i--) begin
            if (r[i]) r = r ^ (12'h013 << (i - 4));
        end
        return r[3:0];
    endfunction

    function automatic logic [11:0] makeCode(input logic [7:0] d, input logic [3:0] flip);
        return {d, refCrc(d) ^ flip};
    endfunction

    // One comparison: counts it, and reports it on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for ready, pulses start for one cycle with the given
    // word, pushes the expected result, then scrambles the inputs so any
    // late re-capture shows up in data_out/addr_out.
    task automatic applyStimulus(input logic [11:0] code, input logic [3:0] addr);
        exp_t e;
        int   n;
        logic [3:0] s;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checkOutput("ready_timeout", {31'd0, ready}, 32'd1);
            return;
        end
        code_in = code;
        addr_in = addr;
        start   = 1'b1;
        s = refCrc(code[11:4]) ^ code[3:0];
        if (s != 4'h0 && modelCnt < 255) modelCnt++;
        e.data     = code[11:4];
        e.addr     = addr;
        e.syn      = s;
        e.err      = (s != 4'h0);
        e.cnt      = 8'(modelCnt);
        e.startCyc = cyc;
        sbQ.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        code_in = 12'($urandom);
        addr_in = 4'($urandom);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic checkHold(input string tag);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_data"}, 32'(data_out), 32'(lastExp.data));
        checkOutput({tag, "_addr"}, 32'(addr_out), 32'(lastExp.addr));
        checkOutput({tag, "_syn"},  32'(syndrome), 32'(lastExp.syn));
        checkOutput({tag, "_err"},  32'(error),    32'(lastExp.err));
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(ready),    32'd1);
        checkOutput({tag, "_valid"}, 32'(valid),    32'd0);
        checkOutput({tag, "_data"},  32'(data_out), 32'd0);
        checkOutput({tag, "_addr"},  32'(addr_out), 32'd0);
        checkOutput({tag, "_syn"},   32'(syndrome), 32'd0);
        checkOutput({tag, "_err"},   32'(error),    32'd0);
        checkOutput({tag, "_cnt"},   32'(err_cnt),  32'd0);
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest pending
    // expectation and arrive exactly 10 cycles after its start was driven.
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_data",    32'(data_out),  32'(e.data));
                checkOutput("sb_addr",    32'(addr_out),  32'(e.addr));
                checkOutput("sb_syn",     32'(syndrome),  32'(e.syn));
                checkOutput("sb_err",     32'(error),     32'(e.err));
                checkOutput("sb_cnt",     32'(err_cnt),   32'(e.cnt));
                checkOutput("sb_latency", 32'(cyc - e.startCyc), 32'd10);
                checkOutput("sb_ready",   32'(ready),     32'd1);
                lastExp = e;
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int n;
        int vSeen;
        rst     = 1'b1;
        start   = 1'b0;
        code_in = 12'h000;
        addr_in = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkZero("reset");

        // Clean words, then hold between pulses.
        applyStimulus(12'h103, 4'h5);
        waitDrain();
        checkHold("hold1");
        applyStimulus(12'h80B, 4'hA);
        waitDrain();
        applyStimulus(12'hFFD, 4'hF);
        waitDrain();
        applyStimulus(12'h000, 4'h0);
        waitDrain();

        // Data-bit error, then check-bit error.
        applyStimulus(12'h183, 4'h1);
        waitDrain();
        checkHold("hold_err");
        applyStimulus(12'h102, 4'h2);
        waitDrain();

        // Starts while busy are ignored; a start in the valid cycle is taken.
        applyStimulus(makeCode(8'hA5, 4'h0), 4'h3);
        repeat (3) begin
            start   = 1'b1;
            code_in = 12'h183;
            addr_in = 4'h9;
            @(negedge clk);
        end
        start = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_valid_seen", 32'(valid), 32'd1);
        applyStimulus(makeCode(8'h5A, 4'h0), 4'hC);
        waitDrain();
        checkHold("hold_b2b");

        // 256 errored words back to back drive the counter to saturation.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(makeCode(8'($urandom), 4'($urandom_range(1, 15))), 4'(i));
        end
        waitDrain();
        checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Reset in the middle of SHIFT aborts the word silently.
        applyStimulus(12'h183, 4'h7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        modelCnt = 0;
        @(negedge clk);
        rst = 1'b0;
        checkZero("abort");
        vSeen = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid === 1'b1) vSeen++;
        end
        checkOutput("abort_no_valid", 32'(vSeen), 32'd0);
        checkOutput("abort_cnt_hold", 32'(err_cnt), 32'd0);

        // Normal operation resumes after the abort.
        applyStimulus(12'h80B, 4'h6);
        waitDrain();
        applyStimulus(12'h102, 4'hE);
        waitDrain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/crc_code_decoder.md
CRC_CODE_DECODER -- requirements
Module: crc_code_decoder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have these ports: code_in input 12, received codeword, [11:4] data and [3:0] check bits.
REQ-003 The block SHALL have these ports: addr_in input 4, address tag accompanying code_in.
REQ-004 The block SHALL have these ports: start input 1, request to check the codeword, sampled only when ready=1.
REQ-005 The block SHALL have these ports: ready output 1, block idle and accepting start.
REQ-006 The block SHALL have these ports: valid output 1, one-cycle pulse marking new results.
REQ-007 The block SHALL have these ports: data_out output 8, captured data bits; addr_out output 4, captured address.
REQ-008 The block SHALL have these ports: syndrome output 4, recomputed check XOR received check; error output 1, syndrome non-zero.
REQ-009 The block SHALL have these ports: err_cnt output 8, saturating count of checks that flagged error.

Function
REQ-010 The check value SHALL be D(x) mod (x^4+x+1). D is data bits [11:4], MSB first. The codeword [11:4] bit maps to x^7.
REQ-011 The check value SHALL be computed serially by a 4-bit LFSR. The LFSR clears to 0 on start.
REQ-012 Per shift, the LFSR SHALL update as new[3]=old[2], new[2]=old[1], new[1]=old[3]^old[0], new[0]=old[3]^in. in is the current data MSB.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, CHECK. ready SHALL be 1 only in IDLE.
REQ-014 IDLE with start=1: capture code_in and addr_in, clear the LFSR, clear the 3-bit shift counter, go to SHIFT.
REQ-015 SHIFT: one LFSR step per cycle. After the 8th step (counter==7), go to CHECK.
REQ-016 CHECK: register syndrome = lfsr ^ code[3:0] and error = |syndrome. Update data_out/addr_out from the captured values. Set valid=1 for the next cycle only. Return to IDLE.
REQ-017 Latency: if start is sampled at edge E0, valid SHALL be high in the cycle following edge E9.
REQ-018 Throughput SHALL be one codeword per 10 cycles. start is accepted in the same cycle valid is high.
REQ-019 start SHALL be ignored while ready=0. Captured inputs SHALL NOT change mid-operation.
REQ-020 data_out, addr_out, syndrome and error SHALL hold their values between valid pulses.
REQ-021 err_cnt SHALL increment in the CHECK cycle when the syndrome is non-zero, saturating at 255.
REQ-022 Detection only: the block SHALL NOT correct the data.

Reset
REQ-023 With rst=1 at a clock edge: state to IDLE; ready=1 in the following cycle; valid=0; data_out, addr_out, syndrome, error, err_cnt, LFSR and counter all 0.
REQ-024 Reset SHALL take priority over start. A reset mid-operation SHALL abort it with no valid pulse and no err_cnt change.

Structure
REQ-025 A shared package SHALL hold: generator polynomial constant 4'b0011 (x^4 term implicit), DATA_W=8, CHK_W=4, ADDR_W=4, and the FSM state enum.
REQ-026 The LFSR step SHALL be one sub-module, crc4_lfsr_step: combinational next-state, reusable by the encoder.

Verification
REQ-027 Clean 0x103 → valid at E9+, data_out=0x10, syndrome=0x0, error=0, err_cnt unchanged.
REQ-028 Clean 0x80B, 0xFFD and 0x000 → syndrome=0x0, error=0 for each.
REQ-029 Data-bit error 0x183 (data 0x18, check 0x3) → syndrome=0x8, error=1, err_cnt +1.
REQ-030 Check-bit error 0x102 → syndrome=0x1, error=1.
REQ-031 start during busy, then back-to-back start on the valid cycle → first ignored, second accepted. 256 errored words → err_cnt=255.
REQ-032 rst asserted during SHIFT → no valid pulse; all outputs 0; the next start completes normally.
